// File: rtl/lesson_sequencer_if.sv
// Lesson-mode bus: player inputs, song ROM port, prompt/tone outputs and scores.
// The sequencer uses the slave modport; the switch/ROM side uses master.
interface lesson_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              START;
    logic              BEAT;
    logic [7:0]        sw;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_note;
    logic [3:0]        target_note;
    logic [7:0]        Led;
    logic [3:0]        tone_note;
    logic              tone_en;
    logic [7:0]        hits;
    logic [7:0]        misses;
    logic [7:0]        errors;
    logic              busy;
    logic              done;

    modport master (
        output START, BEAT, sw, rom_note,
        input  rom_addr, target_note, Led, tone_note, tone_en,
        input  hits, misses, errors, busy, done
    );

    modport slave (
        input  START, BEAT, sw, rom_note,
        output rom_addr, target_note, Led, tone_note, tone_en,
        output hits, misses, errors, busy, done
    );
endinterface

// File: rtl/lesson_sequencer.sv
// Lesson-mode controller: walks the song ROM, prompts one note at a time,
// debounces the switch bank, gates the tone generator and keeps scores.
module lesson_sequencer #(
    parameter int ADDR_W          = 5,
    parameter int SONG_LEN        = 32,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_BEATS   = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    lesson_sequencer_if.slave bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BT_W = $clog2(TIMEOUT_BEATS + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BT_W-1:0]   BT_LIMIT  = BT_W'(TIMEOUT_BEATS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PROMPT,
        S_HOLD,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [3:0]        r_target;
    logic [7:0]        r_led;
    logic [3:0]        r_tone_note;
    logic              r_tone_en;
    logic [7:0]        r_hits;
    logic [7:0]        r_misses;
    logic [7:0]        r_errors;
    logic              r_busy;
    logic              r_done;
    logic [BT_W-1:0]   r_beat_cnt;

    logic [3:0]        r_dec_note;
    logic [DB_W-1:0]   r_db_cnt;
    logic [3:0]        r_stable_note;
    logic              r_press;

    logic [3:0]        w_dec_note;
    logic [BT_W-1:0]   w_beats_next;
    logic              w_timeout;
    logic [7:0]        w_hint;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Ascending scan so the highest set switch overrides lower ones.
    always_comb begin
        w_dec_note = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.sw[i]) begin
                w_dec_note = 4'(8 - i);
            end
        end
    end

    always_comb begin
        w_beats_next = r_beat_cnt;
        if (bus.BEAT && (r_beat_cnt != BT_LIMIT)) begin
            w_beats_next = r_beat_cnt + 1'b1;
        end
    end

    assign w_timeout = (w_beats_next == BT_LIMIT);
    assign w_hint    = ((bus.rom_note >= 4'd1) && (bus.rom_note <= 4'd8)) ?
                       (8'h01 << (4'd8 - bus.rom_note)) : 8'h00;

    // r_press is asserted in the same cycle r_stable_note shows the new note.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dec_note    <= 4'd0;
            r_db_cnt      <= '0;
            r_stable_note <= 4'd0;
            r_press       <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (w_dec_note != r_dec_note) begin
                r_dec_note <= w_dec_note;
                r_db_cnt   <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                if (r_dec_note != r_stable_note) begin
                    r_stable_note <= r_dec_note;
                    r_press       <= (r_dec_note != 4'd0);
                end
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_rom_addr  <= '0;
            r_target    <= 4'd0;
            r_led       <= 8'd0;
            r_tone_note <= 4'd0;
            r_tone_en   <= 1'b0;
            r_hits      <= 8'd0;
            r_misses    <= 8'd0;
            r_errors    <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_beat_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.START) begin
                        r_hits     <= 8'd0;
                        r_misses   <= 8'd0;
                        r_errors   <= 8'd0;
                        r_rom_addr <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    if (bus.rom_note == 4'hF) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (bus.rom_note >= 4'd9) begin
                        r_state <= S_ADVANCE;
                    end else begin
                        r_target   <= bus.rom_note;
                        r_led      <= w_hint;
                        r_beat_cnt <= '0;
                        r_state    <= S_PROMPT;
                    end
                end
                S_PROMPT: begin
                    // A press in the timeout cycle takes priority over the miss.
                    if (r_press) begin
                        if (r_stable_note == r_target) begin
                            r_tone_note <= r_target;
                            r_tone_en   <= 1'b1;
                            r_state     <= S_HOLD;
                        end else begin
                            r_errors   <= sat_inc(r_errors);
                            r_beat_cnt <= w_beats_next;
                        end
                    end else if (w_timeout) begin
                        r_misses <= sat_inc(r_misses);
                        r_target <= 4'd0;
                        r_led    <= 8'd0;
                        r_state  <= S_ADVANCE;
                    end else begin
                        r_beat_cnt <= w_beats_next;
                    end
                end
                S_HOLD: begin
                    if (r_stable_note != r_target) begin
                        r_tone_en   <= 1'b0;
                        r_tone_note <= 4'd0;
                        r_hits      <= sat_inc(r_hits);
                        r_target    <= 4'd0;
                        r_led       <= 8'd0;
                        r_state     <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    r_target <= 4'd0;
                    r_led    <= 8'd0;
                    if (r_rom_addr == ADDR_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_rom_addr <= r_rom_addr + 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr    = r_rom_addr;
    assign bus.target_note = r_target;
    assign bus.Led         = r_led;
    assign bus.tone_note   = r_tone_note;
    assign bus.tone_en     = r_tone_en;
    assign bus.hits        = r_hits;
    assign bus.misses      = r_misses;
    assign bus.errors      = r_errors;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_lesson_sequencer.sv
// Self-checking bench for lesson_sequencer: prompt scoreboard fed from the
// loaded song, plus score/latency/boundary checks after each lesson step.
module tb_lesson_sequencer;
    localparam int ADDR_W   = 5;
    localparam int SONG_LEN = 4;
    localparam int DB       = 4;
    localparam int TO       = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lesson_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    lesson_sequencer #(
        .ADDR_W(ADDR_W),
        .SONG_LEN(SONG_LEN),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_BEATS(TO)
    ) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .bus(bus)
    );

    logic [3:0] rom [0:31];
    always @(posedge clk) bus.rom_note <= rom[bus.rom_addr];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_prompt_q[$];
    logic [3:0] mon_prev = 4'd0;
    int mon_exp;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Each new prompt pops the note the loaded song says should come next.
    always @(negedge clk) begin
        if (rst_n && mon_prev == 4'd0 && bus.target_note != 4'd0) begin
            if (exp_prompt_q.size() == 0) begin
                check_val("prompt_unexpected", bus.target_note, 0);
            end else begin
                mon_exp = exp_prompt_q.pop_front();
                $display("prompt note=%0d led=%b addr=%0d", bus.target_note, bus.Led, bus.rom_addr);
                check_val("prompt_note", bus.target_note, mon_exp);
                check_val("prompt_led", bus.Led, 1 << (8 - mon_exp));
            end
        end
        mon_prev = bus.target_note;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.START = 1'b1; cyc(1); bus.START = 1'b0;
    endtask

    task automatic pulse_beat();
        bus.BEAT = 1'b1; cyc(1); bus.BEAT = 1'b0;
    endtask

    task automatic tap(input logic [7:0] m, input int hold, input int rel);
        bus.sw = m; cyc(hold); bus.sw = 8'h00; cyc(rel);
    endtask

    task automatic wait_prompt(input int limit);
        int k = 0;
        while (bus.target_note == 4'd0 && k < limit) begin cyc(1); k++; end
        check_val("prompt_seen", int'(bus.target_note != 4'd0), 1);
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!bus.done && k < limit) begin cyc(1); k++; end
        check_val("done_seen", bus.done, 1);
        $display("lesson end hits=%0d misses=%0d errors=%0d addr=%0d",
                 bus.hits, bus.misses, bus.errors, bus.rom_addr);
    endtask

    task automatic load_rom(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.START = 1'b0; bus.BEAT = 1'b0; bus.sw = 8'h00;
        for (int i = 0; i < 32; i++) rom[i] = 4'hF;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_target", bus.target_note, 0);
        check_val("rst_hits", bus.hits, 0);

        // Abandon a lesson mid-HOLD with reset
        load_rom(4'd3, 4'd3, 4'd4, 4'hF);
        exp_prompt_q.push_back(3);
        pulse_start();
        wait_prompt(10);
        tap(8'h80, 8, 8);
        check_val("pre_rst_errors", bus.errors, 1);
        bus.sw = 8'h20; cyc(8);
        check_val("pre_rst_tone_en", bus.tone_en, 1);
        check_val("pre_rst_tone_note", bus.tone_note, 3);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_target", bus.target_note, 0);
        check_val("mid_rst_led", bus.Led, 0);
        check_val("mid_rst_tone_en", bus.tone_en, 0);
        check_val("mid_rst_tone_note", bus.tone_note, 0);
        check_val("mid_rst_errors", bus.errors, 0);
        check_val("mid_rst_busy", bus.busy, 0);
        check_val("mid_rst_addr", bus.rom_addr, 0);
        bus.sw = 8'h00;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Correct play of E E F with prompt latency
        exp_prompt_q.push_back(3); exp_prompt_q.push_back(3); exp_prompt_q.push_back(4);
        pulse_start();
        check_val("start_addr", bus.rom_addr, 0);
        check_val("start_busy", bus.busy, 1);
        check_val("start_target", bus.target_note, 0);
        cyc(1);
        check_val("lat1_target", bus.target_note, 0);
        cyc(1);
        check_val("lat2_target", bus.target_note, 3);
        begin
            logic [7:0] masks [3];
            masks[0] = 8'h20; masks[1] = 8'h20; masks[2] = 8'h10;
            for (int n = 0; n < 3; n++) begin
                wait_prompt(20);
                bus.sw = masks[n]; cyc(8);
                check_val("play_tone_on", bus.tone_en, 1);
                bus.sw = 8'h00; cyc(10);
                check_val("play_tone_off", bus.tone_en, 0);
            end
        end
        wait_done(30);
        check_val("play_hits", bus.hits, 3);
        check_val("play_misses", bus.misses, 0);
        check_val("play_errors", bus.errors, 0);
        check_val("play_busy", bus.busy, 0);

        // Wrong press then correct; simultaneous C4+G counts as C4
        load_rom(4'd5, 4'd5, 4'hF, 4'hF);
        exp_prompt_q.push_back(5); exp_prompt_q.push_back(5);
        pulse_start();
        check_val("restart_clears_hits", bus.hits, 0);
        wait_prompt(10);
        tap(8'h80, 8, 8);
        check_val("wrong_errors", bus.errors, 1);
        bus.sw = 8'h08; cyc(8);
        check_val("right_tone_note", bus.tone_note, 5);
        bus.sw = 8'h00; cyc(10);
        check_val("right_hits", bus.hits, 1);
        check_val("right_errors", bus.errors, 1);
        wait_prompt(10);
        tap(8'h88, 8, 8);
        check_val("prio_errors", bus.errors, 2);
        check_val("prio_hits", bus.hits, 1);
        tap(8'h08, 8, 10);
        wait_done(30);
        check_val("wr_hits", bus.hits, 2);

        // Press coinciding with the 8th beat, then a plain timeout
        load_rom(4'd2, 4'd2, 4'hF, 4'hF);
        exp_prompt_q.push_back(2); exp_prompt_q.push_back(2);
        pulse_start();
        wait_prompt(10);
        repeat (7) begin pulse_beat(); cyc(1); end
        bus.sw = 8'h40; cyc(5);
        pulse_beat();
        check_val("race_tone_en", bus.tone_en, 1);
        check_val("race_misses", bus.misses, 0);
        cyc(3); bus.sw = 8'h00; cyc(10);
        check_val("race_hits", bus.hits, 1);
        wait_prompt(10);
        repeat (7) begin pulse_beat(); cyc(1); end
        check_val("to7_misses", bus.misses, 0);
        check_val("to7_addr", bus.rom_addr, 1);
        pulse_beat();
        check_val("to8_misses", bus.misses, 1);
        cyc(1);
        check_val("to_addr_adv", bus.rom_addr, 2);
        wait_done(10);

        // Bounce rejection, START while busy, error saturation
        load_rom(4'd3, 4'hF, 4'hF, 4'hF);
        exp_prompt_q.push_back(3);
        pulse_start();
        wait_prompt(10);
        for (int i = 0; i < 10; i++) begin
            bus.sw = (i % 2 == 0) ? 8'h40 : 8'h00;
            cyc(2);
        end
        bus.sw = 8'h00; cyc(6);
        check_val("bounce_errors", bus.errors, 0);
        check_val("bounce_hits", bus.hits, 0);
        check_val("bounce_tone", bus.tone_en, 0);
        tap(8'h80, 8, 8);
        pulse_start();
        cyc(3);
        check_val("busy_start_errors", bus.errors, 1);
        check_val("busy_start_target", bus.target_note, 3);
        check_val("busy_start_busy", bus.busy, 1);
        for (int i = 0; i < 300; i++) begin
            bus.sw = (i % 2 == 0) ? 8'h80 : 8'h01;
            cyc(6);
        end
        bus.sw = 8'h00; cyc(8);
        check_val("err_sat", bus.errors, 255);
        tap(8'h20, 8, 10);
        wait_done(20);
        check_val("sat_hits", bus.hits, 1);
        check_val("sat_errors_kept", bus.errors, 255);

        // Rests skipped, DONE after last slot without end marker
        load_rom(4'd10, 4'd4, 4'd10, 4'd6);
        exp_prompt_q.push_back(4); exp_prompt_q.push_back(6);
        pulse_start();
        check_val("start_clr_errors", bus.errors, 0);
        wait_prompt(20);
        tap(8'h10, 8, 10);
        wait_prompt(20);
        tap(8'h04, 8, 10);
        wait_done(20);
        check_val("end_addr", bus.rom_addr, 3);
        check_val("end_hits", bus.hits, 2);
        check_val("end_misses", bus.misses, 0);
        check_val("end_errors", bus.errors, 0);

        check_val("prompt_q_empty", exp_prompt_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
